// File: rtl/rmt_pkg.sv
`default_nettype none
// ============================================================================
// Module : rmt_pkg
// Brief  : Shared RMT stage constants and the key_deposit state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package rmt_pkg;

    localparam int CONT_W   = 32;
    localparam int NUM_CONT = 64;
    localparam int NUM_SLOT = 8;
    localparam int IDX_W    = 6;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WRITE   = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/key_deposit_if.sv
`default_nettype none
// ============================================================================
// Module : key_deposit_if
// Brief  : PHV/value input streams and PHV output stream of key_deposit.
// Rev    : 1.0  initial release
// ============================================================================
interface key_deposit_if #(
    parameter int PHV_LEN = 2304,
    parameter int VAL_LEN = 257,
    parameter int DEP_OFF = 56
);
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_valid_in;
    logic               ready_out;
    logic [VAL_LEN-1:0] val_in;
    logic [DEP_OFF-1:0] dep_off_in;
    logic               val_valid_in;
    logic               val_ready_out;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_valid_out;
    logic               ready_in;

    modport master (
        output phv_in, phv_valid_in, val_in, dep_off_in, val_valid_in, ready_in,
        input  ready_out, val_ready_out, phv_out, phv_valid_out
    );

    modport slave (
        input  phv_in, phv_valid_in, val_in, dep_off_in, val_valid_in, ready_in,
        output ready_out, val_ready_out, phv_out, phv_valid_out
    );
endinterface
`default_nettype wire

// File: rtl/key_deposit_merge.sv
`default_nettype none
// ============================================================================
// Module : deposit_merge
// Brief  : Combinational overwrite of up to 8 PHV containers with slot values.
// Rev    : 1.0  initial release
// ============================================================================
module deposit_merge
    import rmt_pkg::*;
#(
    parameter int PHV_LEN = 2304,
    parameter int VAL_LEN = 257,
    parameter int DEP_OFF = 56
) (
    input  wire logic [PHV_LEN-1:0] phv,
    input  wire logic [VAL_LEN-1:0] val,
    input  wire logic [DEP_OFF-1:0] dep_off,
    output logic      [PHV_LEN-1:0] phv_merged
);

    // Slots are scanned in ascending order so a higher slot overrides a
    // lower one that targets the same container.
    always_comb begin
        phv_merged = phv;
        if (val[0]) begin
            for (int k = 0; k < NUM_CONT; k++) begin
                for (int i = 0; i < NUM_SLOT; i++) begin
                    if (dep_off[NUM_SLOT-1-i] &&
                        (dep_off[DEP_OFF-1-i*IDX_W -: IDX_W] == IDX_W'(k))) begin
                        phv_merged[PHV_LEN-1-k*CONT_W -: CONT_W] =
                            val[VAL_LEN-1-i*CONT_W -: CONT_W];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_deposit.sv
`default_nettype none
// ============================================================================
// Module : key_deposit
// Brief  : Joins a PHV and a value set, deposits values into PHV containers.
// Rev    : 1.0  initial release
// ============================================================================
module key_deposit
    import rmt_pkg::*;
#(
    parameter int PHV_LEN  = 2304,
    parameter int VAL_LEN  = 257,
    parameter int DEP_OFF  = 56,
    parameter int STAGE_ID = 0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    key_deposit_if.slave    bus
);

    localparam int STAGE_ID_UNUSED = STAGE_ID;

    state_t             state_q, state_d;
    logic               phv_held_q, phv_held_d;
    logic               val_held_q, val_held_d;
    logic [PHV_LEN-1:0] phv_buf_q, phv_buf_d;
    logic [VAL_LEN-1:0] val_buf_q, val_buf_d;
    logic [DEP_OFF-1:0] dep_buf_q, dep_buf_d;
    logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
    logic               phv_valid_out_q, phv_valid_out_d;
    logic               w_ready_out;
    logic               w_val_ready_out;
    logic [PHV_LEN-1:0] w_merged;

    deposit_merge #(
        .PHV_LEN (PHV_LEN),
        .VAL_LEN (VAL_LEN),
        .DEP_OFF (DEP_OFF)
    ) u_merge (
        .phv        (phv_buf_q),
        .val        (val_buf_q),
        .dep_off    (dep_buf_q),
        .phv_merged (w_merged)
    );

    always_comb begin
        state_d         = state_q;
        phv_held_d      = phv_held_q;
        val_held_d      = val_held_q;
        phv_buf_d       = phv_buf_q;
        val_buf_d       = val_buf_q;
        dep_buf_d       = dep_buf_q;
        phv_out_d       = phv_out_q;
        phv_valid_out_d = phv_valid_out_q;
        w_ready_out     = 1'b0;
        w_val_ready_out = 1'b0;

        unique case (state_q)
            ST_COLLECT: begin
                w_ready_out     = ~phv_held_q;
                w_val_ready_out = ~val_held_q;
                if (bus.phv_valid_in && w_ready_out) begin
                    phv_buf_d  = bus.phv_in;
                    phv_held_d = 1'b1;
                end
                if (bus.val_valid_in && w_val_ready_out) begin
                    val_buf_d  = bus.val_in;
                    dep_buf_d  = bus.dep_off_in;
                    val_held_d = 1'b1;
                end
                // Joining on the next-cycle flags lets a same-cycle arrival
                // move straight to WRITE.
                if (phv_held_d && val_held_d) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                phv_out_d       = w_merged;
                phv_valid_out_d = 1'b1;
                phv_held_d      = 1'b0;
                val_held_d      = 1'b0;
                state_d         = ST_OUT;
            end
            ST_OUT: begin
                if (bus.ready_in) begin
                    phv_valid_out_d = 1'b0;
                    state_d         = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_COLLECT;
            phv_held_q      <= 1'b0;
            val_held_q      <= 1'b0;
            phv_buf_q       <= '0;
            val_buf_q       <= '0;
            dep_buf_q       <= '0;
            phv_out_q       <= '0;
            phv_valid_out_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            phv_held_q      <= phv_held_d;
            val_held_q      <= val_held_d;
            phv_buf_q       <= phv_buf_d;
            val_buf_q       <= val_buf_d;
            dep_buf_q       <= dep_buf_d;
            phv_out_q       <= phv_out_d;
            phv_valid_out_q <= phv_valid_out_d;
        end
    end

    assign bus.ready_out     = w_ready_out;
    assign bus.val_ready_out = w_val_ready_out;
    assign bus.phv_out       = phv_out_q;
    assign bus.phv_valid_out = phv_valid_out_q;

endmodule
`default_nettype wire

// File: doc/key_deposit.md
# key_deposit

Writes action/lookup result values back into the 32-bit containers of a PHV, mirroring the key extractor in reverse. It joins a PHV stream and a value stream that may arrive on different cycles, then overwrites up to 8 selected containers. It forwards the modified PHV downstream under a valid/ready handshake. It sits after the action engine in each RMT stage, ahead of the next stage's key extractor.

## Interface
- PHV_LEN, 2304 (4\*8\*64+256): PHV width; 64 × 32-bit containers on top, 256-bit metadata below
- VAL_LEN, 257 (4\*8\*8+1): 8 × 32-bit values plus valid flag bit [0]
- DEP_OFF, 56 (8\*6+8): 8 × 6-bit container indices, then an 8-bit slot enable mask in [7:0]
- STAGE_ID, 0: stage number, informational

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- phv_in  in  PHV_LEN  incoming PHV
- phv_valid_in  in  1  phv_in valid
- ready_out  out  1  PHV input can be accepted
- val_in  in  VAL_LEN  values; slot i = val_in[VAL_LEN-1-i\*32 -: 32]; bit 0 = value-set valid
- dep_off_in  in  DEP_OFF  slot i index = dep_off_in[DEP_OFF-1-i\*6 -: 6]; enable i = dep_off_in[7-i]
- val_valid_in  in  1  val_in/dep_off_in valid
- val_ready_out  out  1  value input can be accepted
- phv_out  out  PHV_LEN  modified PHV (registered)
- phv_valid_out  out  1  phv_out valid (registered)
- ready_in  in  1  downstream ready

## Operation
- Container k occupies phv[PHV_LEN-1-k\*32 -: 32], k = 0..63. Metadata bits [255:0] always pass through unchanged.
- States: COLLECT, WRITE, OUT.
- COLLECT:
  - ready_out = ~phv_held; val_ready_out = ~val_held.
  - phv_valid_in & ready_out captures phv_in and sets phv_held.
  - val_valid_in & val_ready_out captures val_in and dep_off_in and sets val_held.
  - Both streams may be accepted in the same cycle.
  - When both held flags are set (including flags set this cycle), next state is WRITE.
- WRITE: ready_out = val_ready_out = 0.
  - phv_out <= merge(held PHV, held values); phv_valid_out <= 1.
  - Clear both held flags; next state is OUT.
- merge:
  - Start from the held PHV. For i = 0..7, if enable i and value flag bit 0 == 1, container[index i] <= value slot i.
  - If the flag bit is 0, the PHV passes through unmodified.
  - When two enabled slots target the same container, the higher slot number wins.
- OUT: ready_out = val_ready_out = 0.
  - Hold phv_out and phv_valid_out stable while ready_in = 0.
  - When ready_in = 1, the transfer completes: phv_valid_out <= 0 and next state is COLLECT.
- No arithmetic is performed; indices are 6 bits, so all 64 containers are addressable and there is no out-of-range case.

## Timing
- Reset values: phv_out = 0, phv_valid_out = 0, held flags = 0, state = COLLECT.
  - After reset, ready_out = 1 and val_ready_out = 1.
- Both inputs accepted at edge T:
  - WRITE during cycle T..T+1.
  - phv_valid_out visible after edge T+1. Latency is 2 edges from the later of the two input acceptances.
- Skew between the streams is unbounded. The first arrival is held; its ready stays low until WRITE completes.
- With ready_in held high, throughput is one PHV per 3 cycles. The next accept can occur in the cycle after the OUT handshake.
- Reset asserted mid-operation discards all held data and any pending output; no partial PHV is emitted.

## Structure
- Shared package rmt_pkg:
  - CONT_W = 32, NUM_CONT = 64, NUM_SLOT = 8, IDX_W = 6
  - state encoding for COLLECT / WRITE / OUT
- One combinational sub-module, deposit_merge: inputs held PHV, values, dep_off; output merged PHV. This lets the slot-priority logic be verified standalone.
- The top level holds the FSM, input holding registers and output register.

## Test plan
- PHV with container k = k, values slot0 = 0xDEADBEEF at index 5 with enable 0x80, flag = 1, both valid same cycle → 2 edges later, container 5 = 0xDEADBEEF, all other containers and metadata unchanged.
- Same stimulus with val_in[0] = 0 → phv_out equals phv_in bit-exact.
- Slot0 and slot7 both target index 10 with values 0x1 and 0x7, enable 0xFF → container 10 = 0x7.
- PHV arrives at T, values at T+5:
  - ready_out is 0 from T+1 until the OUT handshake.
  - phv_valid_out rises at T+7.
- ready_in held 0 for 4 cycles in OUT, with new phv_valid_in pulses offered → phv_out stable, ready_out = 0, inputs not accepted; the first is accepted the cycle after ready_in = 1.
- rst_n low for 1 cycle while in WRITE → phv_valid_out = 0 and both readies = 1 on the next cycle; no output emitted.
